// File: rtl/ifetch_stream_pkg.sv
// ifetch_stream_pkg: shared fetch constants and redirect target computation
package ifetch_stream_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int JUMP_SPLIT = 28;
  function automatic logic [63:0] redirect_target(input logic [63:0] base, input logic is_jump,
                                                  input logic is_branch, input logic [15:0] off,
                                                  input logic [25:0] jaddr);
    logic [63:0] seq;
    seq = base + 64'(INSTR_BYTES);
    return is_jump ? (((seq >> JUMP_SPLIT) << JUMP_SPLIT) | {36'b0, jaddr, 2'b00})
         : is_branch ? seq + {{46{off[15]}}, off, 2'b00} : seq;
  endfunction
endpackage

// File: rtl/ifetch_slot_buf.sv
// ifetch_slot_buf: in-order slot buffer with separate alloc, fill and read pointers
module ifetch_slot_buf #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     alloc_i,
  input  logic [ADDR_W-1:0]        alloc_pc_i,
  input  logic                     fill_i,
  input  logic [INSTR_W-1:0]       fill_instr_i,
  input  logic                     read_i,
  output logic                     head_valid_o,
  output logic [ADDR_W-1:0]        head_pc_o,
  output logic [INSTR_W-1:0]       head_instr_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0] ptr_t;
  localparam ptr_t ONE = 1;
  ptr_t alloc_q, fill_q, read_q;
  logic [DEPTH-1:0] filled_q;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PW-1:0] a_idx, f_idx, r_idx;
  assign a_idx = alloc_q[PW-1:0];
  assign f_idx = fill_q[PW-1:0];
  assign r_idx = read_q[PW-1:0];
  // pointer and filled-bit bookkeeping; flush drops every slot at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush_i) begin
      alloc_q <= '0;
      fill_q <= '0;
      read_q <= '0;
      filled_q <= '0;
    end else begin
      if (alloc_i) alloc_q <= alloc_q + ONE;
      if (fill_i) begin
        fill_q <= fill_q + ONE;
        filled_q[f_idx] <= 1'b1;
      end
      if (read_i) begin
        read_q <= read_q + ONE;
        filled_q[r_idx] <= 1'b0;
      end
    end
  end
  // slot payload storage; validity lives in filled_q so no reset is needed
  always_ff @(posedge clk) begin
    if (alloc_i) pc_mem[a_idx] <= alloc_pc_i;
    if (fill_i) instr_mem[f_idx] <= fill_instr_i;
  end
  assign head_valid_o = filled_q[r_idx];
  assign head_pc_o = head_valid_o ? pc_mem[r_idx] : '0;
  assign head_instr_o = head_valid_o ? instr_mem[r_idx] : '0;
  assign count_o = alloc_q - read_q;
endmodule

// File: rtl/ifetch_stream.sv
// ifetch_stream: decoupled instruction fetch with in-order memory and redirect flush
module ifetch_stream
  import ifetch_stream_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic               is_jump,
  input  logic               is_branch,
  input  logic [ADDR_W-1:0]  redirect_base_pc,
  input  logic [15:0]        branch_offset,
  input  logic [25:0]        jump_addr,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_plus4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t ONE = 1;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt, head_pc;
  cnt_t os_q, os_d, drop_q, drop_d, alloc_cnt;
  logic en_q, req_v, req_hs, fill, head_valid;
  logic [INSTR_W-1:0] head_instr;
  assign tgt = ADDR_W'(redirect_target(64'(redirect_base_pc), is_jump, is_branch, branch_offset, jump_addr));
  assign req_v = en_q && fetch_en && !redirect_valid && alloc_cnt < cnt_t'(FIFO_DEPTH) && drop_q == '0;
  assign req_hs = req_v && imem_req_ready;
  assign fill = imem_rsp_valid && drop_q == '0 && !redirect_valid;
  assign imem_req_valid = req_v;
  assign imem_req_addr = req_v ? pc_q : '0;
  assign out_valid = head_valid;
  assign out_instr = head_instr;
  assign out_pc = head_pc;
  assign out_pc_plus4 = head_valid ? head_pc + ADDR_W'(INSTR_BYTES) : '0;
  // next PC, in-flight request count and wrong-path responses still to discard
  always_comb begin
    os_d = os_q + (req_hs ? ONE : '0) - (imem_rsp_valid ? ONE : '0);
    drop_d = redirect_valid ? os_q - (imem_rsp_valid ? ONE : '0)
           : drop_q - ((imem_rsp_valid && drop_q != '0) ? ONE : '0);
    pc_d = redirect_valid ? tgt : req_hs ? pc_q + ADDR_W'(INSTR_BYTES) : pc_q;
  end
  // en_q keeps requests off while reset is held and for the first edge after it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= 1'b0;
      pc_q <= RESET_PC;
      os_q <= '0;
      drop_q <= '0;
    end else begin
      en_q <= 1'b1;
      pc_q <= pc_d;
      os_q <= os_d;
      drop_q <= drop_d;
    end
  end
  ifetch_slot_buf #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_buf (
    .clk(clk),
    .reset_n(reset_n),
    .flush_i(redirect_valid),
    .alloc_i(req_hs),
    .alloc_pc_i(pc_q),
    .fill_i(fill),
    .fill_instr_i(imem_rsp_data),
    .read_i(head_valid && out_ready),
    .head_valid_o(head_valid),
    .head_pc_o(head_pc),
    .head_instr_o(head_instr),
    .count_o(alloc_cnt)
  );
endmodule

// File: tb/tb_ifetch_stream.sv
// tb_ifetch_stream: randomized scoreboard bench for ifetch_stream
module tb_ifetch_stream;
  localparam int D = 4;
  localparam logic [31:0] RPC = 32'h100;
  logic clk = 0, reset_n = 1, fetch_en = 0, redirect_valid = 0, is_jump = 0, is_branch = 0;
  logic [31:0] redirect_base_pc = 0;
  logic [15:0] branch_offset = 0;
  logic [25:0] jump_addr = 0;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] imem_req_addr, imem_rsp_data = 0;
  logic out_valid, out_ready = 0;
  logic [31:0] out_instr, out_pc, out_pc_plus4;

  always #5 clk = ~clk;

  ifetch_stream #(.ADDR_W(32), .INSTR_W(32), .FIFO_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .is_jump(is_jump), .is_branch(is_branch), .redirect_base_pc(redirect_base_pc),
    .branch_offset(branch_offset), .jump_addr(jump_addr), .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t mem_q[$];
  logic [31:0] exp_q[$];
  int checks = 0, errors = 0, cyc = 0, stale = 0, n_out = 0, n_req = 0;
  int p_fe = 100, p_rdy = 100, p_ordy = 100, p_redir = 0, lat_lo = 1, lat_hi = 1;
  logic [31:0] mpc = RPC, hs_addr = 0;
  bit prev_redir = 0, hs_seen = 0;

  function automatic logic [31:0] ins_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] tgt(logic [31:0] b, bit j, bit br, logic [15:0] o, logic [25:0] ja);
    logic [31:0] s;
    s = b + 32'd4;
    if (j) return (s & 32'hF000_0000) | (32'(ja) * 32'd4);
    if (br) return s + 32'(int'($signed(o)) * 4);
    return s;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    cyc++;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data = ins_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = $urandom;
    end
    fetch_en = $urandom_range(99) < p_fe;
    imem_req_ready = $urandom_range(99) < p_rdy;
    out_ready = $urandom_range(99) < p_ordy;
    redirect_valid = $urandom_range(99) < p_redir;
    is_jump = 1'($urandom_range(1));
    is_branch = 1'($urandom_range(1));
    redirect_base_pc = $urandom & 32'hFFFF_FFFC;
    branch_offset = 16'($urandom);
    jump_addr = 26'($urandom);
  endtask

  task automatic end_cycle();
    @(negedge clk);
    hs_seen = 0;
    if (!reset_n) return;
    check("req_valid", imem_req_valid, fetch_en && !redirect_valid && exp_q.size() < D && stale == 0);
    if (prev_redir) check("out_valid_after_redirect", out_valid, 0);
    if (imem_req_valid) check("req_addr", imem_req_addr, mpc);
    if (imem_req_valid && imem_req_ready) begin
      hs_seen = 1;
      hs_addr = imem_req_addr;
      exp_q.push_back(mpc);
      mem_q.push_back('{mpc, cyc + int'($urandom_range(lat_hi, lat_lo))});
      mpc += 4;
      n_req++;
    end
    if (redirect_valid) begin
      mpc = tgt(redirect_base_pc, is_jump, is_branch, branch_offset, jump_addr);
      exp_q.delete();
      stale = mem_q.size();
    end else if (imem_rsp_valid && stale > 0) stale--;
    prev_redir = redirect_valid;
  endtask

  task automatic run(int n);
    repeat (n) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  task automatic wait_req(string name, logic [31:0] exp);
    for (int i = 0; i < 30; i++) begin
      begin_cycle();
      fetch_en = 1;
      imem_req_ready = 1;
      out_ready = 1;
      redirect_valid = 0;
      end_cycle();
      if (hs_seen) break;
    end
    check(name, {hs_seen, hs_addr}, {1'b1, exp});
  endtask

  task automatic do_reset(int hold);
    #2 reset_n = 0;
    imem_rsp_valid = 0;
    redirect_valid = 0;
    imem_req_ready = 0;
    fetch_en = 1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc_plus4", out_pc_plus4, 0);
    mem_q.delete();
    exp_q.delete();
    mpc = RPC;
    stale = 0;
    prev_redir = 0;
    repeat (hold) @(posedge clk);
    #3 reset_n = 1;
  endtask

  // decode-side monitor: pops the scoreboard on each accepted instruction
  always @(negedge clk) begin
    #1;
    if (reset_n && !redirect_valid && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_out got pc %h want no valid output", out_pc);
      end else begin
        check("out_pc", out_pc, exp_q[0]);
        check("out_instr", out_instr, ins_of(exp_q[0]));
        check("out_pc_plus4", out_pc_plus4, exp_q[0] + 32'd4);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    int n0;
    bit found;
    do_reset(3);
    wait_req("first_req", RPC);
    n0 = n_out;
    run(20);
    check("throughput", n_out - n0 >= 16, 1);
    p_fe = 0;
    run(8);
    p_fe = 100;
    p_ordy = 0;
    n0 = n_req;
    run(10);
    check("stall_req_count", n_req - n0, D);
    check("stall_req_valid", imem_req_valid, 0);
    p_ordy = 100;
    n0 = n_out;
    run(12);
    check("drain_count", n_out - n0 >= 8, 1);
    lat_lo = 3;
    lat_hi = 3;
    run(6);
    begin_cycle();
    redirect_valid = 1;
    is_branch = 1;
    is_jump = 0;
    redirect_base_pc = 32'h200;
    branch_offset = 16'hFFFE;
    end_cycle();
    wait_req("branch_target", 32'h1FC);
    run(10);
    lat_lo = 1;
    lat_hi = 2;
    begin_cycle();
    redirect_valid = 1;
    is_jump = 1;
    is_branch = 1;
    redirect_base_pc = 32'h3000_0010;
    jump_addr = 26'h40;
    end_cycle();
    wait_req("jump_target", 32'h3000_0100);
    lat_hi = 3;
    run(5);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      begin_cycle();
      if (imem_rsp_valid && out_valid) begin
        redirect_valid = 1;
        is_branch = 1;
        out_ready = 1;
        found = 1;
      end
      end_cycle();
    end
    check("redirect_with_rsp_seen", found, 1);
    run(8);
    lat_lo = 2;
    lat_hi = 2;
    run(6);
    begin_cycle();
    do_reset(2);
    wait_req("restart_pc", RPC);
    p_fe = 85;
    p_rdy = 70;
    p_ordy = 70;
    p_redir = 4;
    lat_lo = 1;
    lat_hi = 4;
    run(3000);
    p_fe = 0;
    p_redir = 0;
    p_ordy = 100;
    run(20);
    check("final_exp_empty", exp_q.size(), 0);
    check("final_mem_empty", mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
